issue_scoreboard: RTL
=====================

# issue_scoreboard

Single-entry issue stage between the instruction decoder and the execute stage. It holds one decoded instruction, tracks outstanding register writes with a per-register pending counter, and releases the instruction only when its source registers have no pending writers. Flushes from branch/jump resolution discard the held instruction without disturbing writes already in flight.

## Interface

Parameters:

- PAYLOAD_W, 64: width of the opaque decoded-instruction payload passed through to execute.
- CNT_W, 2: width of each per-register pending counter. Maximum outstanding writes per register is 2^CNT_W-1.

Ports:

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_dec_valid  in  1  decoder presents an instruction.
- o_dec_ready  out  1  stage can accept the decoder's instruction this cycle.
- i_dec_payload  in  PAYLOAD_W  decoded instruction fields.
- i_dec_rs1_addr, i_dec_rs2_addr, i_dec_rd_addr  in  5 each  register indices.
- i_dec_rs1_used, i_dec_rs2_used  in  1 each  the source is actually read.
- o_issue_valid  out  1  held instruction is hazard-free and offered to execute.
- i_issue_ready  in  1  execute accepts this cycle.
- o_issue_payload  out  PAYLOAD_W  held payload.
- o_issue_rd_addr  out  5  held rd.
- i_wb_valid  in  1  a register write retires this cycle.
- i_wb_addr  in  5  register written.
- i_flush  in  1  discard the held instruction and any instruction arriving this cycle.
- o_busy  out  1  held entry valid or any counter nonzero.
- o_sb_err  out  1  sticky flag: writeback to a register whose counter is 0.

## Operation

- State: held_valid, held payload, held rs1/rs2/rd plus use bits, and 32 counters cnt[r] of CNT_W bits. cnt[0] is always 0.
- Hazard is asserted when any of the following holds, using registered cnt values:
  - rs1_used and rs1 != 0 and cnt[rs1] != 0
  - rs2_used and rs2 != 0 and cnt[rs2] != 0
  - rd != 0 and cnt[rd] is at its maximum
- No same-cycle writeback bypass. A writeback unblocks a waiting source on the following cycle.
- o_issue_valid = held_valid & !hazard & !i_flush.
- issue_fire = o_issue_valid & i_issue_ready.
- o_dec_ready = !held_valid | issue_fire | i_flush. This is combinational from i_issue_ready and i_flush.
- dec_fire = i_dec_valid & o_dec_ready & !i_flush. It loads the held entry and sets held_valid=1.
- If there is no dec_fire and either issue_fire or i_flush occurs, held_valid is cleared.
- Counter update per register r != 0:
  - inc = issue_fire & (held rd == r)
  - dec = i_wb_valid & (i_wb_addr == r) & (cnt[r] != 0)
  - Net change is +1 for inc only, -1 for dec only, and 0 for both or neither.
- Writeback to r=0 is ignored.
- Writeback to r != 0 with cnt[r]==0 leaves cnt unchanged and sets o_sb_err, which stays set until reset.
- i_flush does not touch the counters. Already-issued instructions still write back.
- Reset values: held_valid=0, all cnt=0, o_issue_valid=0, o_dec_ready=1, o_busy=0, o_sb_err=0, o_issue_payload/o_issue_rd_addr=0. Reset overrides every other input in the same cycle.

## Timing

- Decode to issue latency is 1 cycle minimum. An instruction accepted at edge N presents o_issue_valid in cycle N+1 if hazard-free.
- Full throughput is one instruction per cycle when no hazards occur. Back-to-back accept and issue happen in the same cycle.
- The counter increment for an issue at edge N is visible to a dependent instruction held in cycle N+1. A dependent instruction that directly follows therefore stalls.
- A writeback at edge N clears the hazard for a held instruction from cycle N+1.
- While hazard is high, held contents are stable and o_dec_ready=0, unless i_flush is asserted.
- Simultaneous issue and writeback to the same rd leaves cnt unchanged.
- Simultaneous i_flush and i_dec_valid: the incoming instruction is dropped, and held_valid=0 next cycle.
- Reset asserted mid-stall drops the held instruction and clears all counters on the next edge.

## Test plan

- Independent stream: 4 back-to-back ALU instructions, rd=1..4, sources x0, i_issue_ready=1 -> issued on 4 consecutive cycles starting 1 cycle after first accept; cnt[1..4]=1.
- RAW stall: issue rd=5, then hold rs1=5. Assert wb x5 three cycles later -> o_issue_valid low until the cycle after wb, then high; cnt[5] returns to 0.
- WAW saturation with CNT_W=2: issue 3 writes to x7 with no wb, then hold a 4th write to x7 -> stalls. One wb x7 -> 4th issues next cycle, and cnt[7] stays 3.
- Flush: held instruction stalled on x9, i_flush with i_dec_valid=1 -> both dropped, o_issue_valid=0, cnt[9] unchanged, later wb x9 clears it.
- Same-cycle issue rd=3 and wb x3 with cnt[3]=1 -> cnt[3] stays 1. Separately, wb x12 with cnt[12]=0 -> o_sb_err=1 and stays 1 until i_rst.
- x0 handling: sources x0 never stall, rd=x0 never increments, wb x0 does not set o_sb_err. Reset mid-stall -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//
// Single-entry issue stage sitting between the instruction decoder and the
// execute stage. One decoded instruction is held at a time. A 32-entry table of
// pending-write counters records how many issued-but-not-retired writes target
// each architectural register. The held instruction is released to execute only
// when none of its sources has a pending writer and its destination counter
// still has headroom. A flush discards the held instruction (and any
// instruction arriving in the same cycle) but leaves the counters alone,
// because instructions that already issued still write back.
//
// Parameters
//   PAYLOAD_W : width of the opaque decoded-instruction payload
//   CNT_W     : width of each pending counter (max outstanding = 2^CNT_W-1)
//
// Ports
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_dec_valid/o_dec_ready, i_dec_payload, i_dec_rs1/rs2/rd_addr,
//   i_dec_rs1/rs2_used  : decoder handshake and decoded register fields
//   o_issue_valid/i_issue_ready, o_issue_payload, o_issue_rd_addr
//                       : execute handshake and held instruction fields
//   i_wb_valid, i_wb_addr : register write retiring this cycle
//   i_flush             : discard held and incoming instruction
//   o_busy              : held entry valid or any write still pending
//   o_sb_err            : sticky, writeback seen for a register with no
//                         pending write
// -----------------------------------------------------------------------------
module issue_scoreboard #(
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_dec_valid,
  output logic                 o_dec_ready,
  input  logic [PAYLOAD_W-1:0] i_dec_payload,
  input  logic [4:0]           i_dec_rs1_addr,
  input  logic [4:0]           i_dec_rs2_addr,
  input  logic [4:0]           i_dec_rd_addr,
  input  logic                 i_dec_rs1_used,
  input  logic                 i_dec_rs2_used,
  output logic                 o_issue_valid,
  input  logic                 i_issue_ready,
  output logic [PAYLOAD_W-1:0] o_issue_payload,
  output logic [4:0]           o_issue_rd_addr,
  input  logic                 i_wb_valid,
  input  logic [4:0]           i_wb_addr,
  input  logic                 i_flush,
  output logic                 o_busy,
  output logic                 o_sb_err
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Held entry state
  logic                 held_valid_q,    held_valid_d;
  logic [PAYLOAD_W-1:0] held_payload_q,  held_payload_d;
  logic [4:0]           held_rs1_q,      held_rs1_d;
  logic [4:0]           held_rs2_q,      held_rs2_d;
  logic [4:0]           held_rd_q,       held_rd_d;
  logic                 held_rs1_used_q, held_rs1_used_d;
  logic                 held_rs2_used_q, held_rs2_used_d;

  // Pending-write counters; entry 0 is held at zero
  logic [CNT_W-1:0]     cnt_q [32];
  logic [CNT_W-1:0]     cnt_d [32];

  logic                 sb_err_q, sb_err_d;

  // Handshake / hazard terms
  logic                 hazard_s;
  logic                 issue_valid_s;
  logic                 issue_fire_s;
  logic                 dec_ready_s;
  logic                 dec_fire_s;
  logic                 any_pending_s;

  // A source blocks issue when it is really read, is not x0, and has a writer
  // still in flight.
  function automatic logic src_blocked(input logic             used,
                                       input logic [4:0]       addr,
                                       input logic [CNT_W-1:0] cnt);
    return used && (addr != 5'd0) && (cnt != CNT_ZERO);
  endfunction

  // Hazard uses only registered counter values: a writeback never bypasses into
  // the same cycle, and a saturated destination counter blocks a further issue.
  always_comb begin
    hazard_s = src_blocked(held_rs1_used_q, held_rs1_q, cnt_q[held_rs1_q]) ||
               src_blocked(held_rs2_used_q, held_rs2_q, cnt_q[held_rs2_q]) ||
               ((held_rd_q != 5'd0) && (cnt_q[held_rd_q] == CNT_MAX));
  end

  // Handshakes; dec_ready is intentionally combinational so a held entry that
  // issues or is flushed can be replaced in the same cycle.
  always_comb begin
    issue_valid_s = held_valid_q && !hazard_s && !i_flush;
    issue_fire_s  = issue_valid_s && i_issue_ready;
    dec_ready_s   = !held_valid_q || issue_fire_s || i_flush;
    dec_fire_s    = i_dec_valid && dec_ready_s && !i_flush;
  end

  // Held entry next state: load on accept, otherwise drain on issue or flush.
  always_comb begin
    held_valid_d    = held_valid_q;
    held_payload_d  = held_payload_q;
    held_rs1_d      = held_rs1_q;
    held_rs2_d      = held_rs2_q;
    held_rd_d       = held_rd_q;
    held_rs1_used_d = held_rs1_used_q;
    held_rs2_used_d = held_rs2_used_q;
    if (dec_fire_s) begin
      held_valid_d    = 1'b1;
      held_payload_d  = i_dec_payload;
      held_rs1_d      = i_dec_rs1_addr;
      held_rs2_d      = i_dec_rs2_addr;
      held_rd_d       = i_dec_rd_addr;
      held_rs1_used_d = i_dec_rs1_used;
      held_rs2_used_d = i_dec_rs2_used;
    end else if (issue_fire_s || i_flush) begin
      held_valid_d    = 1'b0;
    end else begin
      held_valid_d    = held_valid_q;
    end
  end

  // Counter next state: +1 on issue to r, -1 on writeback to a nonzero r,
  // unchanged when both or neither happen. Issue cannot overflow because a
  // saturated destination is a hazard.
  always_comb begin
    logic inc_v;
    logic dec_v;
    inc_v    = 1'b0;
    dec_v    = 1'b0;
    cnt_d[0] = CNT_ZERO;
    for (int r = 1; r < 32; r++) begin
      inc_v = issue_fire_s && (held_rd_q == 5'(r));
      dec_v = i_wb_valid && (i_wb_addr == 5'(r)) && (cnt_q[r] != CNT_ZERO);
      case ({inc_v, dec_v})
        2'b10:   cnt_d[r] = cnt_q[r] + CNT_ONE;
        2'b01:   cnt_d[r] = cnt_q[r] - CNT_ONE;
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
  end

  // Sticky error: a retiring write that the scoreboard never saw issue.
  always_comb begin
    sb_err_d = sb_err_q ||
               (i_wb_valid && (i_wb_addr != 5'd0) && (cnt_q[i_wb_addr] == CNT_ZERO));
  end

  // Any outstanding write keeps the stage busy.
  always_comb begin
    any_pending_s = 1'b0;
    for (int r = 1; r < 32; r++) begin
      any_pending_s = any_pending_s || (cnt_q[r] != CNT_ZERO);
    end
  end

  // State registers with synchronous reset overriding all other inputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      held_valid_q    <= 1'b0;
      held_payload_q  <= {PAYLOAD_W{1'b0}};
      held_rs1_q      <= 5'd0;
      held_rs2_q      <= 5'd0;
      held_rd_q       <= 5'd0;
      held_rs1_used_q <= 1'b0;
      held_rs2_used_q <= 1'b0;
      sb_err_q        <= 1'b0;
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
    end else begin
      held_valid_q    <= held_valid_d;
      held_payload_q  <= held_payload_d;
      held_rs1_q      <= held_rs1_d;
      held_rs2_q      <= held_rs2_d;
      held_rd_q       <= held_rd_d;
      held_rs1_used_q <= held_rs1_used_d;
      held_rs2_used_q <= held_rs2_used_d;
      sb_err_q        <= sb_err_d;
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign o_issue_valid   = issue_valid_s;
  assign o_dec_ready     = dec_ready_s;
  assign o_issue_payload = held_payload_q;
  assign o_issue_rd_addr = held_rd_q;
  assign o_busy          = held_valid_q || any_pending_s;
  assign o_sb_err        = sb_err_q;

endmodule
